// File: rtl/tx_slot_buffer.sv
// tx_slot_buffer
//   Multi-slot transmit packet buffer. The packet writer fills the open slot
//   with byte-masked, size-aligned stores and commits it with a byte count.
//   The MAC reads committed slots in order, one word per request, and gets
//   the data one cycle later. It frees each slot with an explicit release.
//
// Ports
//   clk_i, reset_n_i        clock; asynchronous active-low reset
//   wr_slot_ready_o         a slot is open for writing (buffer not full)
//   wr_v_i/addr/data/op     byte store into the open slot (2^op bytes)
//   wr_commit_v_i/size_i    close the open slot with a packet length
//   wr_abort_i              discard the open slot (abort wins over commit)
//   rd_slot_v_o, rd_size_o  head slot is committed, and its length
//   rd_v_i, rd_addr_i       word read from the head slot (bw-aligned)
//   rd_data_o, rd_data_v_o  registered read data and its valid strobe
//   rd_release_i            free the head slot
//   occupancy_o             committed, unreleased slots
//   err_misaligned_o        sticky: a misaligned or oversize access was dropped
//   err_size_o              sticky: a commit with an illegal length was dropped
//   err_clear_i             clears both sticky flags (wins over new errors)
module tx_slot_buffer #(
    parameter  int slot_p       = 2,
    parameter  int data_width_p = 64,
    parameter  int els_p        = 2048,
    parameter  int size_width_p = 16,
    localparam int aw           = $clog2(els_p),
    localparam int bw           = data_width_p / 8,
    localparam int lw           = $clog2(bw),
    localparam int ow           = $clog2(slot_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    output logic                    wr_slot_ready_o,
    input  logic                    wr_v_i,
    input  logic [aw-1:0]           wr_addr_i,
    input  logic [data_width_p-1:0] wr_data_i,
    input  logic [2:0]              wr_op_size_i,
    input  logic                    wr_commit_v_i,
    input  logic [size_width_p-1:0] wr_commit_size_i,
    input  logic                    wr_abort_i,
    output logic                    rd_slot_v_o,
    output logic [size_width_p-1:0] rd_size_o,
    input  logic                    rd_v_i,
    input  logic [aw-1:0]           rd_addr_i,
    output logic [data_width_p-1:0] rd_data_o,
    output logic                    rd_data_v_o,
    input  logic                    rd_release_i,
    output logic [ow-1:0]           occupancy_o,
    output logic                    err_misaligned_o,
    output logic                    err_size_o,
    input  logic                    err_clear_i
);

    localparam int words_lp = els_p / bw;
    localparam int ww       = aw - lw;
    localparam int pw       = $clog2(slot_p);

    logic [data_width_p-1:0] mem [slot_p][words_lp];

    logic [pw-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ow-1:0]           occ_q, occ_d;
    logic [size_width_p-1:0] size_q [slot_p];
    logic [size_width_p-1:0] size_d [slot_p];
    logic [data_width_p-1:0] rd_data_q, rd_data_d;
    logic                    rd_data_v_q, rd_data_v_d;
    logic                    err_mis_q, err_mis_d;
    logic                    err_size_q, err_size_d;

    logic                    ready, head_v;
    logic [lw-1:0]           wr_lane;
    logic [ww-1:0]           wr_word, rd_word_addr;
    logic                    wr_misaligned, rd_misaligned;
    logic                    store_ok, read_ok, abort_ok;
    logic                    commit_req, commit_legal, commit_ok, release_ok;
    logic [bw-1:0]           wr_be;
    logic [data_width_p-1:0] wr_data_sh, rd_word;

    assign ready        = (occ_q != ow'(slot_p));
    assign head_v       = (occ_q != '0);
    assign wr_lane      = wr_addr_i[lw-1:0];
    assign wr_word      = wr_addr_i[aw-1:lw];
    assign rd_word_addr = rd_addr_i[aw-1:lw];
    assign wr_data_sh   = wr_data_i << {wr_lane, 3'b000};
    assign rd_word      = mem[rd_ptr_q][rd_word_addr];

    // A store of 2^op bytes needs its low op address bits clear; ops wider
    // than the bank word can never be aligned.
    always_comb begin
        wr_misaligned = (int'(wr_op_size_i) > lw);
        for (int b = 0; b < lw; b++) begin
            if (b < int'(wr_op_size_i) && wr_addr_i[b]) begin
                wr_misaligned = 1'b1;
            end
        end
    end

    always_comb begin
        wr_be = '0;
        for (int b = 0; b < bw; b++) begin
            wr_be[b] = (b >= int'(wr_lane)) &&
                       (b < int'(wr_lane) + (1 << int'(wr_op_size_i)));
        end
    end

    assign rd_misaligned = (rd_addr_i[lw-1:0] != '0);
    assign store_ok      = wr_v_i && ready && !wr_misaligned;
    assign read_ok       = rd_v_i && head_v && !rd_misaligned;
    assign abort_ok      = wr_abort_i && ready;
    assign commit_req    = wr_commit_v_i && ready && !wr_abort_i;
    assign commit_legal  = (wr_commit_size_i != '0) &&
                           (wr_commit_size_i <= size_width_p'(els_p));
    assign commit_ok     = commit_req && commit_legal;
    assign release_ok    = rd_release_i && head_v;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        size_d      = size_q;
        rd_data_d   = rd_data_q;
        rd_data_v_d = read_ok;
        err_mis_d   = err_mis_q;
        err_size_d  = err_size_q;

        if (abort_ok) begin
            size_d[wr_ptr_q] = '0;
        end else if (commit_ok) begin
            size_d[wr_ptr_q] = wr_commit_size_i;
            wr_ptr_d         = wr_ptr_q + pw'(1);
        end

        if (release_ok) begin
            rd_ptr_d = rd_ptr_q + pw'(1);
        end

        case ({commit_ok, release_ok})
            2'b10:   occ_d = occ_q + ow'(1);
            2'b01:   occ_d = occ_q - ow'(1);
            default: occ_d = occ_q;
        endcase

        // Reading at acceptance uses the pre-release head pointer, so a
        // read paired with a release still returns the head slot's data.
        if (read_ok) begin
            rd_data_d = rd_word;
        end

        if (err_clear_i) begin
            err_mis_d  = 1'b0;
            err_size_d = 1'b0;
        end else begin
            if ((wr_v_i && ready && wr_misaligned) ||
                (rd_v_i && head_v && rd_misaligned)) begin
                err_mis_d = 1'b1;
            end
            if (commit_req && !commit_legal) begin
                err_size_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            rd_data_q   <= '0;
            rd_data_v_q <= 1'b0;
            err_mis_q   <= 1'b0;
            err_size_q  <= 1'b0;
            for (int s = 0; s < slot_p; s++) begin
                size_q[s] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            rd_data_q   <= rd_data_d;
            rd_data_v_q <= rd_data_v_d;
            err_mis_q   <= err_mis_d;
            err_size_q  <= err_size_d;
            size_q      <= size_d;
        end
    end

    // Packet memory is not reset; a slot's contents only matter after commit.
    always_ff @(posedge clk_i) begin
        if (store_ok) begin
            for (int b = 0; b < bw; b++) begin
                if (wr_be[b]) begin
                    mem[wr_ptr_q][wr_word][8*b +: 8] <= wr_data_sh[8*b +: 8];
                end
            end
        end
    end

    assign wr_slot_ready_o  = ready;
    assign rd_slot_v_o      = head_v;
    assign rd_size_o        = head_v ? size_q[rd_ptr_q] : '0;
    assign rd_data_o        = rd_data_q;
    assign rd_data_v_o      = rd_data_v_q;
    assign occupancy_o      = occ_q;
    assign err_misaligned_o = err_mis_q;
    assign err_size_o       = err_size_q;

endmodule

// File: tb/tb_tx_slot_buffer.sv
// Testbench for tx_slot_buffer.
//   Main instance (2 slots, 64-bit, 2048 bytes) is checked every cycle against
//   a packet-level model (byte array per slot + queue of committed packets),
//   plus literal expectations at the interesting points. Two further
//   instances at 32 and 128 bits repeat the fill-and-drain sequence.
module tb_tx_slot_buffer;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic        wr_v = 0, commit_v = 0, abort = 0, rd_v = 0, rd_rel = 0, err_clr = 0;
    logic [10:0] wr_addr = 0, rd_addr = 0;
    logic [63:0] wr_data = 0;
    logic [2:0]  wr_op = 0;
    logic [15:0] commit_size = 0;
    logic        ready, rd_slot_v, rd_data_v, err_mis, err_size;
    logic [15:0] rd_size;
    logic [63:0] rd_data;
    logic [1:0]  occ;

    tx_slot_buffer dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .wr_slot_ready_o(ready), .wr_v_i(wr_v), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_op_size_i(wr_op),
        .wr_commit_v_i(commit_v), .wr_commit_size_i(commit_size),
        .wr_abort_i(abort), .rd_slot_v_o(rd_slot_v), .rd_size_o(rd_size),
        .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .rd_data_v_o(rd_data_v), .rd_release_i(rd_rel), .occupancy_o(occ),
        .err_misaligned_o(err_mis), .err_size_o(err_size), .err_clear_i(err_clr)
    );

    // width-variant instances: shared address/data/size, private strobes
    logic [10:0]  x_addr = 0;
    logic [127:0] x_data = 0;
    logic [2:0]   x_op = 0;
    logic [15:0]  x_size = 0;
    logic a_wv = 0, a_cv = 0, a_rv = 0, a_rl = 0;
    logic b_wv = 0, b_cv = 0, b_rv = 0, b_rl = 0;
    logic a_ready, a_slot_v, a_dv, a_emis, a_esz;
    logic b_ready, b_slot_v, b_dv, b_emis, b_esz;
    logic [15:0]  a_size, b_size;
    logic [31:0]  a_data;
    logic [127:0] b_data;
    logic [1:0]   a_occ, b_occ;

    tx_slot_buffer #(.data_width_p(32)) dut32 (
        .clk_i(clk), .reset_n_i(reset_n),
        .wr_slot_ready_o(a_ready), .wr_v_i(a_wv), .wr_addr_i(x_addr),
        .wr_data_i(x_data[31:0]), .wr_op_size_i(x_op),
        .wr_commit_v_i(a_cv), .wr_commit_size_i(x_size),
        .wr_abort_i(1'b0), .rd_slot_v_o(a_slot_v), .rd_size_o(a_size),
        .rd_v_i(a_rv), .rd_addr_i(x_addr), .rd_data_o(a_data),
        .rd_data_v_o(a_dv), .rd_release_i(a_rl), .occupancy_o(a_occ),
        .err_misaligned_o(a_emis), .err_size_o(a_esz), .err_clear_i(1'b0)
    );

    tx_slot_buffer #(.data_width_p(128)) dut128 (
        .clk_i(clk), .reset_n_i(reset_n),
        .wr_slot_ready_o(b_ready), .wr_v_i(b_wv), .wr_addr_i(x_addr),
        .wr_data_i(x_data), .wr_op_size_i(x_op),
        .wr_commit_v_i(b_cv), .wr_commit_size_i(x_size),
        .wr_abort_i(1'b0), .rd_slot_v_o(b_slot_v), .rd_size_o(b_size),
        .rd_v_i(b_rv), .rd_addr_i(x_addr), .rd_data_o(b_data),
        .rd_data_v_o(b_dv), .rd_release_i(b_rl), .occupancy_o(b_occ),
        .err_misaligned_o(b_emis), .err_size_o(b_esz), .err_clear_i(1'b0)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- packet-level model of the main instance ----------------
    localparam int SLOTS = 2;
    localparam int ELS   = 2048;
    localparam int BW    = 8;

    typedef struct { int slot; int size; } pkt_t;
    pkt_t        pkt_q[$];
    logic [7:0]  m_mem [SLOTS][ELS];
    bit          m_wr  [SLOTS][ELS];
    int          m_open = 0;
    logic [63:0] m_rd_exp = 0;
    bit          m_rd_known = 1;
    bit          m_rdv = 0, m_emis = 0, m_esz = 0;
    bit          m_ready, m_head, m_mis_set, m_sz_set, m_rdv_n;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_q.delete();
            m_open = 0; m_rd_exp = 0; m_rd_known = 1;
            m_rdv = 0; m_emis = 0; m_esz = 0;
        end else begin
            m_ready   = pkt_q.size() < SLOTS;
            m_head    = pkt_q.size() > 0;
            m_mis_set = 0; m_sz_set = 0; m_rdv_n = 0;
            if (rd_v && m_head) begin
                if (rd_addr % BW != 0) m_mis_set = 1;
                else begin
                    m_rdv_n = 1; m_rd_known = 1;
                    for (int b = 0; b < BW; b++) begin
                        m_rd_exp[8*b +: 8] = m_mem[pkt_q[0].slot][rd_addr + b];
                        if (!m_wr[pkt_q[0].slot][rd_addr + b]) m_rd_known = 0;
                    end
                end
            end
            if (wr_v && m_ready) begin
                if (wr_op > 3 || (wr_addr % (1 << wr_op)) != 0) m_mis_set = 1;
                else for (int k = 0; k < (1 << wr_op); k++) begin
                    m_mem[m_open][wr_addr + k] = wr_data[8*k +: 8];
                    m_wr[m_open][wr_addr + k]  = 1;
                end
            end
            if (rd_rel && m_head) void'(pkt_q.pop_front());
            if (m_ready && !abort && commit_v) begin
                if (commit_size >= 1 && commit_size <= ELS) begin
                    pkt_q.push_back('{m_open, int'(commit_size)});
                    m_open = (m_open + 1) % SLOTS;
                end else m_sz_set = 1;
            end
            if (err_clr) begin m_emis = 0; m_esz = 0; end
            else begin m_emis = m_emis | m_mis_set; m_esz = m_esz | m_sz_set; end
            m_rdv = m_rdv_n;
        end
    end

    always @(negedge clk) begin
        chk("m_ready", ready, pkt_q.size() < SLOTS);
        chk("m_rd_slot_v", rd_slot_v, pkt_q.size() > 0);
        chk("m_rd_size", rd_size, pkt_q.size() > 0 ? pkt_q[0].size : 0);
        chk("m_occupancy", occ, pkt_q.size());
        chk("m_rd_data_v", rd_data_v, m_rdv);
        if (m_rd_known) chk("m_rd_data", rd_data, m_rd_exp);
        chk("m_err_mis", err_mis, m_emis);
        chk("m_err_size", err_size, m_esz);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        wr_v = 0; commit_v = 0; abort = 0; rd_v = 0; rd_rel = 0; err_clr = 0;
        a_wv = 0; a_cv = 0; a_rv = 0; a_rl = 0;
        b_wv = 0; b_cv = 0; b_rv = 0; b_rl = 0;
    endtask

    task automatic store(input int addr, input logic [63:0] d, input int op);
        wr_v = 1; wr_addr = 11'(addr); wr_data = d; wr_op = 3'(op); tick();
    endtask
    task automatic commit(input int sz);
        commit_v = 1; commit_size = 16'(sz); tick();
    endtask
    task automatic read(input int addr);
        rd_v = 1; rd_addr = 11'(addr); tick();
    endtask
    task automatic release_head();
        rd_rel = 1; tick();
    endtask

    task automatic aux_fill_drain(input bit wide);
        int bwx;
        logic [127:0] pat;
        bwx = wide ? 16 : 4;
        for (int i = 0; i < 8; i++) begin
            pat = {4{32'h1111_1111}};
            x_data = wide ? pat * 128'(i + 1) : {96'b0, pat[31:0] * 32'(i + 1)};
            x_addr = 11'(i * bwx); x_op = wide ? 3'd4 : 3'd2;
            if (wide) b_wv = 1; else a_wv = 1;
            tick();
        end
        x_size = 16'(8 * bwx);
        if (wide) b_cv = 1; else a_cv = 1;
        tick();
        chk("aux_slot_v", wide ? b_slot_v : a_slot_v, 1'b1);
        chk("aux_size", wide ? b_size : a_size, 8 * bwx);
        for (int i = 0; i < 8; i++) begin
            x_addr = 11'(i * bwx);
            if (wide) b_rv = 1; else a_rv = 1;
            tick();
            pat = {4{32'h1111_1111}};
            chk("aux_rd_v", wide ? b_dv : a_dv, 1'b1);
            if (wide) chk("aux128_data", b_data, pat * 128'(i + 1));
            else      chk("aux32_data", a_data, pat[31:0] * 32'(i + 1));
        end
        if (wide) b_rl = 1; else a_rl = 1;
        tick();
        chk("aux_occ", wide ? b_occ : a_occ, 0);
        chk("aux_ready", wide ? b_ready : a_ready, 1'b1);
        chk("aux_errs", wide ? {b_emis, b_esz} : {a_emis, a_esz}, 0);
    endtask

    initial begin
        #1 reset_n = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_slot_v", rd_slot_v, 1'b0);
        chk("rst_size", rd_size, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_data_v", rd_data_v, 1'b0);
        chk("rst_occ", occ, 0);
        chk("rst_errs", {err_mis, err_size}, 0);
        reset_n = 1;
        tick();

        // fill and drain, slot 0
        for (int i = 0; i < 8; i++) store(i * 8, 64'h1111_1111_1111_1111 * 64'(i + 1), 3);
        commit(64);
        chk("fd_slot_v", rd_slot_v, 1'b1);
        chk("fd_size", rd_size, 64);
        for (int i = 0; i < 8; i++) begin
            read(i * 8);
            chk("fd_data_v", rd_data_v, 1'b1);
            chk("fd_data", rd_data, 64'h1111_1111_1111_1111 * 64'(i + 1));
        end
        release_head();
        chk("fd_occ", occ, 0);

        // byte and half stores, slot 1
        store(0, 64'h0, 3);
        store(3, 64'hAB, 0);
        store(6, 64'hCDEF, 1);
        commit(8);
        read(0);
        chk("bh_data", rd_data, 64'hCDEF_0000_AB00_0000);
        release_head();

        // full and wrap
        store(0, 64'hA0A0_A0A0_A0A0_A0A0, 3);
        store(8, 64'hA1A1_A1A1_A1A1_A1A1, 3);
        commit(16);
        store(0, 64'hB0B0_B0B0_B0B0_B0B0, 3);
        commit(8);
        chk("full_ready", ready, 1'b0);
        chk("full_occ", occ, 2);
        commit(10);
        chk("full_commit_ign", occ, 2);
        chk("full_head_size", rd_size, 16);
        rd_rel = 1; wr_v = 1; wr_addr = 8; wr_data = 64'hDEAD_DEAD_DEAD_DEAD; wr_op = 3;
        tick();
        chk("rel_ready", ready, 1'b1);
        chk("rel_occ", occ, 1);
        store(0, 64'hC0C0_C0C0_C0C0_C0C0, 3);
        commit(16);
        read(0);
        chk("wrap_slot1", rd_data, 64'hB0B0_B0B0_B0B0_B0B0);
        release_head();
        read(0);
        chk("wrap_slot0", rd_data, 64'hC0C0_C0C0_C0C0_C0C0);
        read(8);
        chk("dropped_store", rd_data, 64'hA1A1_A1A1_A1A1_A1A1);
        chk("wrap_size", rd_size, 16);
        release_head();

        // errors
        store(2, 64'h1234_5678, 2);
        chk("mis_store", err_mis, 1'b1);
        err_clr = 1; tick();
        chk("mis_clear", err_mis, 1'b0);
        store(0, 64'h1, 4);
        chk("oversize_op", err_mis, 1'b1);
        err_clr = 1; wr_v = 1; wr_addr = 1; wr_op = 1; tick();
        chk("clear_prio", err_mis, 1'b0);
        commit(0);
        chk("size0_err", err_size, 1'b1);
        chk("size0_occ", occ, 0);
        err_clr = 1; tick();
        commit(2049);
        chk("size2049_err", err_size, 1'b1);
        chk("size2049_ready", ready, 1'b1);
        store(1, 64'h0, 1);
        chk("both_errs", {err_mis, err_size}, 2'b11);
        err_clr = 1; tick();
        chk("both_clear", {err_mis, err_size}, 2'b00);

        // abort
        store(0, 64'h5555_5555_5555_5555, 3);
        abort = 1; commit_v = 1; commit_size = 8; tick();
        chk("abort_occ", occ, 0);
        commit(16);
        chk("abort_size", rd_size, 16);
        read(0);
        chk("abort_data", rd_data, 64'h5555_5555_5555_5555);
        read(4);
        chk("mis_read_v", rd_data_v, 1'b0);
        chk("mis_read_err", err_mis, 1'b1);
        chk("mis_read_hold", rd_data, 64'h5555_5555_5555_5555);
        rd_v = 1; rd_addr = 0; rd_rel = 1; tick();
        chk("rd_rel_data_v", rd_data_v, 1'b1);
        chk("rd_rel_occ", occ, 0);
        release_head();
        chk("rel_empty", occ, 0);
        err_clr = 1; tick();

        // reset mid-packet
        store(0, 64'h7777_7777_7777_7777, 3);
        commit(8);
        chk("pre_rst_occ", occ, 1);
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("async_slot_v", rd_slot_v, 1'b0);
        chk("async_occ", occ, 0);
        chk("async_ready", ready, 1'b1);
        @(negedge clk);
        reset_n = 1;
        tick();

        // commit and release in the same cycle
        store(0, 64'h9999_9999_9999_9999, 3);
        commit(24);
        store(0, 64'hAAAA_AAAA_AAAA_AAAA, 3);
        commit_v = 1; commit_size = 32; rd_rel = 1; tick();
        chk("cr_occ", occ, 1);
        chk("cr_size", rd_size, 32);
        read(0);
        chk("cr_data", rd_data, 64'hAAAA_AAAA_AAAA_AAAA);
        release_head();

        // data width variants
        aux_fill_drain(1'b0);
        aux_fill_drain(1'b1);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
